// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: FSM state
// encoding, parity-type encoding and the supported oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample position counter (edge_cnt) and bit counter (bit_cnt).
// edge_cnt runs 0..prescale_l-1 while enabled; each wrap advances bit_cnt.
// decision marks the last oversample of a bit, where the sampler's vote is valid.
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK_CTRL,
    input  logic                  RST_CTRL,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic [PRESCALE_W-1:0] prescale_l,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  decision
);

    logic [PRESCALE_W-1:0] edge_last;

    assign edge_last = prescale_l - PRESCALE_W'(1);
    assign decision  = cnt_en && (edge_cnt == edge_last);

    // Counter register: clear has priority, otherwise count and wrap at prescale-1
    always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
        if (!RST_CTRL) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (cnt_en) begin
            if (edge_cnt == edge_last) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller. Detects the start edge, drives the sampler
// enable and oversample position, deserializes the voted bits LSB first and
// checks start, parity and stop.
// Output strobes: data_valid, par_err and stp_err are single-cycle pulses with
// no back-pressure; P_DATA changes only together with a data_valid pulse and
// holds its value otherwise (including after any error).
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK_CTRL,
    input  logic                  RST_CTRL,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output rx_state_e             fsm_state
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 4);

    rx_state_e             state, next_state;
    logic [PRESCALE_W-1:0] prescale_l;
    logic                  par_en_l, par_typ_l;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  perr;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  decision;
    logic                  stop_dec;
    logic                  samp_en_nxt, dv_nxt, pe_nxt, se_nxt;

    assign fsm_state = state;

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (BIT_CNT_W)
    ) u_cnt (
        .CLK_CTRL   (CLK_CTRL),
        .RST_CTRL   (RST_CTRL),
        .cnt_en     (state != ST_IDLE),
        .cnt_clr    (next_state == ST_IDLE),
        .prescale_l (prescale_l),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .decision   (decision)
    );

    // FSM state register
    always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
        if (!RST_CTRL) state <= ST_IDLE;
        else           state <= next_state;
    end

    // Next-state logic: transitions only on the decision cycle, except the start edge
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (!RX_IN) next_state = ST_START;
            ST_START:  if (decision) next_state = sampled_bit ? ST_IDLE : ST_DATA;
            ST_DATA:   if (decision && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                           next_state = par_en_l ? ST_PARITY : ST_STOP;
            ST_PARITY: if (decision) next_state = ST_STOP;
            ST_STOP:   if (decision) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Output decode: next-cycle values of the registered outputs
    always_comb begin
        stop_dec    = (state == ST_STOP) && decision;
        samp_en_nxt = (next_state != ST_IDLE);
        dv_nxt      = stop_dec && sampled_bit && !perr;
        pe_nxt      = stop_dec && perr;
        se_nxt      = stop_dec && !sampled_bit;
    end

    // Registered outputs; P_DATA only loads on a clean frame
    always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
        if (!RST_CTRL) begin
            data_samp_en <= 1'b0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            P_DATA       <= '0;
        end else begin
            data_samp_en <= samp_en_nxt;
            data_valid   <= dv_nxt;
            par_err      <= pe_nxt;
            stp_err      <= se_nxt;
            if (dv_nxt) P_DATA <= shift_reg;
        end
    end

    // Frame datapath: latch settings at the start edge, shift data, hold parity verdict
    always_ff @(posedge CLK_CTRL or negedge RST_CTRL) begin
        if (!RST_CTRL) begin
            prescale_l <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= PAR_EVEN;
            shift_reg  <= '0;
            perr       <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && !RX_IN) begin
                prescale_l <= prescale;
                par_en_l   <= PAR_EN;
                par_typ_l  <= PAR_TYP;
            end
            if ((state == ST_DATA) && decision)
                shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            if ((state == ST_PARITY) && decision)
                perr <= (sampled_bit != ((^shift_reg) ^ par_typ_l));
            else if (stop_dec)
                perr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames followed by random frames.
// A simple mid-bit sampler model drives sampled_bit; the expected outcome of
// each frame is derived from ones-counting of the transmitted bits.
module tb_uart_rx_frame_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en, par_typ;
  logic          sb = 1'b1;
  logic          data_samp_en;
  logic [PW-1:0] edge_cnt;
  logic [DW-1:0] p_data;
  logic          data_valid, par_err, stp_err;
  rx_state_e     fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int samp_ps = 8;
  logic [DW-1:0] exp_pdata = '0;

  typedef struct packed {
    logic [31:0]   cyc;
    logic          dv;
    logic          pe;
    logic          se;
    logic [DW-1:0] data;
  } ev_t;
  ev_t exp_q[$];

  uart_rx_frame_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK_CTRL     (clk),
    .RST_CTRL     (rst_n),
    .RX_IN        (rx_in),
    .prescale     (prescale),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .sampled_bit  (sb),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .P_DATA       (p_data),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err),
    .fsm_state    (fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // sampler model: one sample at mid-bit, held through the decision cycle
  always @(posedge clk) begin
    if (!data_samp_en) sb <= 1'b1;
    else if (int'(edge_cnt) == samp_ps / 2) sb <= rx_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every output pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && (data_valid || par_err || stp_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("data_valid", data_valid, e.dv);
        check("par_err", par_err, e.pe);
        check("stp_err", stp_err, e.se);
        check("p_data", p_data, e.data);
      end
    end
  end

  // driver: call at #1 after a posedge; returns #1 after the stop-decision edge
  task automatic send_frame(input logic [7:0] b, input int ps, input logic pen,
                            input logic ptyp, input logic pbit, input logic stop,
                            input logic scramble);
    logic bits [0:10];
    int   nb;
    int   c;
    int   ones;
    ev_t  e;
    nb = pen ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9] = pen ? pbit : stop;
    bits[10] = stop;
    // expected outcome from ones-counting over the transmitted bits
    ones = $countones(b);
    e.cyc = 32'(cyc + 1 + nb * ps);
    e.pe  = pen && (((ones + int'(pbit)) % 2) != int'(ptyp));
    e.se  = !stop;
    e.dv  = !e.pe && !e.se;
    if (e.dv) exp_pdata = b;
    e.data = exp_pdata;
    exp_q.push_back(e);
    c = cyc;
    samp_ps  = ps;
    prescale = PW'(ps);
    par_en   = pen;
    par_typ  = ptyp;
    rx_in    = 1'b0;
    @(posedge clk); #1;
    check("samp_en_at_start", data_samp_en, 1'b1);
    check("edge_cnt_at_start", edge_cnt, 0);
    if (scramble) begin
      prescale = PW'((ps == 8) ? 32 : 8);
      par_en   = ~pen;
      par_typ  = ~ptyp;
    end
    for (int k = 1; k < nb; k++) begin
      repeat (ps) @(posedge clk);
      #1 rx_in = bits[k];
    end
    repeat (ps) @(posedge clk);
    #1 rx_in = 1'b1;
    if (cyc != c + 1 + nb * ps) check("driver_alignment", cyc, c + 1 + nb * ps);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("data_valid_low", data_valid, 1'b0);
  endtask

  function automatic logic good_par(input logic [7:0] b, input logic ptyp);
    return logic'(($countones(b) % 2) == 1) ^ ptyp;
  endfunction

  initial begin
    logic [7:0] b;
    int         ps;
    logic       pen, ptyp, pbit, stop;

    // reset
    rst_n = 1'b0; rx_in = 1'b1; prescale = PW'(PRESCALE_8); par_en = 1'b0; par_typ = PAR_EVEN;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_samp_en", data_samp_en, 1'b0);
    check("rst_edge_cnt", edge_cnt, 0);
    check("rst_p_data", p_data, 0);
    check("rst_pulses", {data_valid, par_err, stp_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_edge_cnt", edge_cnt, 0);
    check("idle_samp_en", data_samp_en, 1'b0);

    // 1: good even-parity frame
    send_frame(8'hA5, PRESCALE_8, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    drain();
    check("t1_p_data", p_data, 8'hA5);

    // 2: odd parity expected, wrong parity bit sent
    send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b0);
    drain();
    check("t2_p_data_held", p_data, 8'hA5);

    // 3: stop bit low, then line stays low briefly: false frame must be rejected
    send_frame(8'h5A, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (3 * PRESCALE_8) @(posedge clk);
    #1;
    check("t3_rearm_idle", fsm_state, ST_IDLE);
    check("t3_queue", exp_q.size(), 0);
    check("t3_p_data_held", p_data, 8'hA5);

    // 4: start glitch
    prescale = PW'(PRESCALE_16); samp_ps = PRESCALE_16;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_in_start", fsm_state, ST_START);
    check("t4_samp_en_high", data_samp_en, 1'b1);
    repeat (PRESCALE_16) @(posedge clk);
    #1;
    check("t4_back_idle", fsm_state, ST_IDLE);
    check("t4_samp_en_low", data_samp_en, 1'b0);
    check("t4_edge_cnt", edge_cnt, 0);
    check("t4_p_data_held", p_data, 8'hA5);
    check("t4_queue", exp_q.size(), 0);

    // 5: back-to-back frames at prescale 32, start edge on the first idle cycle
    send_frame(8'h00, PRESCALE_32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, PRESCALE_32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    drain();
    check("t5_p_data", p_data, 8'hFF);

    // 6: reset in the middle of the data bits, then a clean frame
    samp_ps = PRESCALE_8; prescale = PW'(PRESCALE_8); par_en = 1'b0;
    b = 8'h81;
    rx_in = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      repeat (PRESCALE_8) @(posedge clk);
      #1 rx_in = (k <= 8) ? b[(k-1) % 8] : 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("t6_in_data", fsm_state, ST_DATA);
    rst_n = 1'b0;
    #1;
    exp_pdata = '0;
    check("t6_rst_state", fsm_state, ST_IDLE);
    check("t6_rst_p_data", p_data, 0);
    check("t6_rst_samp_en", data_samp_en, 1'b0);
    check("t6_rst_edge_cnt", edge_cnt, 0);
    check("t6_rst_pulses", {data_valid, par_err, stp_err}, 0);
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(8'h81, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0);
    drain();
    check("t6_p_data", p_data, 8'h81);

    // random frames: mixed prescale/parity, injected errors, settings scrambled mid-frame
    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       ps = PRESCALE_8;
        1:       ps = PRESCALE_16;
        default: ps = PRESCALE_32;
      endcase
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pbit = good_par(b, ptyp) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, ps, pen, ptyp, pbit, stop, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    check("final_p_data", p_data, exp_pdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
